// File: rtl/mouse_1351_if.sv
// rtl/mouse_1351_if.sv - HID mouse packet bundle feeding the 1351 emulator
interface mouse_1351_if;
   logic [1:0] mouse_btns;
   logic [7:0] mouse_x;
   logic [7:0] mouse_y;
   logic       mouse_strobe;

   modport master (output mouse_btns, output mouse_x, output mouse_y, output mouse_strobe);
   modport slave  (input  mouse_btns, input  mouse_x, input  mouse_y, input  mouse_strobe);
endinterface

// File: rtl/mouse_1351.sv
// rtl/mouse_1351.sv - Commodore 1351 proportional mouse emulator
// Accumulates USB deltas and drains them per frame into wrapping 6-bit SID pot positions.
module mouse_1351 #(
   parameter int          MAX_STEP  = 31,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable_i,
   input  logic                tick_i,
   mouse_1351_if.slave         hid_i,
   output logic [7:0]          pot_x_o,
   output logic [7:0]          pot_y_o,
   output logic [4:0]          joy_btn_o
);

   localparam logic signed [9:0]  STEP_MAX = 10'(MAX_STEP);
   localparam logic signed [9:0]  STEP_MIN = -10'(MAX_STEP);
   localparam logic signed [10:0] PEND_MAX = 11'sd511;
   localparam logic signed [10:0] PEND_MIN = -11'sd511;

   logic signed [9:0] pend_x_q, pend_y_q, pend_x_d, pend_y_d;
   logic [5:0]        pos_x_q, pos_y_q, pos_x_d, pos_y_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [1:0]        btn_q, btn_d;
   logic signed [9:0] step_x, step_y;
   logic signed [10:0] dx, dy;
   logic [7:0]        pot_x_q, pot_y_q;
   logic [4:0]        joy_btn_q;

   function automatic logic signed [9:0] clamp_step(input logic signed [9:0] p);
      if (p > STEP_MAX)      return STEP_MAX;
      else if (p < STEP_MIN) return STEP_MIN;
      else                   return p;
   endfunction

   // Sum at 11 bits so pend +/- step + delta cannot overflow before saturation.
   function automatic logic signed [9:0] next_pend(input logic signed [9:0]  p,
                                                   input logic signed [9:0]  step,
                                                   input logic signed [10:0] delta);
      logic signed [10:0] s;
      s = $signed({p[9], p}) - $signed({step[9], step}) + delta;
      if (s > PEND_MAX)      return PEND_MAX[9:0];
      else if (s < PEND_MIN) return PEND_MIN[9:0];
      else                   return s[9:0];
   endfunction

   always_comb begin
      step_x = '0;
      step_y = '0;
      dx     = '0;
      dy     = '0;
      btn_d  = btn_q;
      lfsr_d = lfsr_q;
      if (tick_i) begin
         step_x = clamp_step(pend_x_q);
         step_y = clamp_step(pend_y_q);
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
      if (hid_i.mouse_strobe) begin
         dx    = $signed({{3{hid_i.mouse_x[7]}}, hid_i.mouse_x});
         // USB Y grows downward, the 1351 grows upward
         dy    = -$signed({{3{hid_i.mouse_y[7]}}, hid_i.mouse_y});
         btn_d = hid_i.mouse_btns;
      end
      pend_x_d = next_pend(pend_x_q, step_x, dx);
      pend_y_d = next_pend(pend_y_q, step_y, dy);
      pos_x_d  = pos_x_q + step_x[5:0];
      pos_y_d  = pos_y_q + step_y[5:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_x_q  <= '0;
         pend_y_q  <= '0;
         pos_x_q   <= '0;
         pos_y_q   <= '0;
         lfsr_q    <= LFSR_SEED;
         btn_q     <= '0;
         pot_x_q   <= 8'hFF;
         pot_y_q   <= 8'hFF;
         joy_btn_q <= '0;
      end else if (!enable_i) begin
         // Open paddle while deselected; position and noise are frozen
         pend_x_q  <= '0;
         pend_y_q  <= '0;
         pot_x_q   <= 8'hFF;
         pot_y_q   <= 8'hFF;
         joy_btn_q <= '0;
      end else begin
         pend_x_q  <= pend_x_d;
         pend_y_q  <= pend_y_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         lfsr_q    <= lfsr_d;
         btn_q     <= btn_d;
         pot_x_q   <= {1'b0, pos_x_d, lfsr_d[0]};
         pot_y_q   <= {1'b0, pos_y_d, lfsr_d[1]};
         joy_btn_q <= {btn_d[0], 3'b000, btn_d[1]};
      end
   end

   assign pot_x_o   = pot_x_q;
   assign pot_y_o   = pot_y_q;
   assign joy_btn_o = joy_btn_q;

endmodule

// File: doc/mouse_1351.md
# mouse_1351

Commodore 1351 proportional-mouse emulator. Sits directly downstream of the HID block, consuming its mouse packet outputs (`mouse_btns`, `mouse_x`, `mouse_y`, `mouse_strobe`). It accumulates USB relative motion and drains it into 6-bit wrapping positions at a rate the C64 driver can follow. It presents SID POTX/POTY values plus joystick-style button bits to the control-port mux.

## Interface

Parameters:
- `MAX_STEP`, 31: maximum position change per axis per tick; must be ≤31.
- `LFSR_SEED`, 16'hACE1: noise LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  mouse emulation selected on this port.
- `tick`  in  1  one-cycle sample pulse, once per video frame (vsync).
- `mouse_btns`  in  2  bit0 left, bit1 right, active-high.
- `mouse_x`  in  8  signed two's-complement X delta, positive = right.
- `mouse_y`  in  8  signed two's-complement Y delta, positive = down (USB).
- `mouse_strobe`  in  1  one-cycle pulse; deltas valid this cycle.
- `pot_x`  out  8  SID POTX value.
- `pot_y`  out  8  SID POTY value.
- `joy_btn`  out  5  active-high joystick bits {fire, right, left, down, up}.

## Operation

- State:
  - `pend_x`, `pend_y`: signed 10-bit pending motion.
  - `pos_x`, `pos_y`: 6-bit unsigned positions.
  - `lfsr`: 16-bit noise register.
- On `mouse_strobe` (with `enable`=1):
  - `pend_x += sext(mouse_x)`.
  - `pend_y -= sext(mouse_y)`. Y is inverted because the 1351 uses positive = up.
- On `tick` (with `enable`=1), per axis:
  - `step = clamp(pend, -MAX_STEP, +MAX_STEP)`.
  - `pos = (pos + step) mod 64`, wrapping both directions.
  - `pend -= step`.
  - `lfsr` shifts once: Fibonacci, taps 16,14,13,11, feedback into bit0.
- Simultaneous `tick` and `mouse_strobe`:
  - `step` is computed from the old `pend`.
  - Then `pend_next = pend - step + delta`. No delta is lost.
- Saturation: `pend_next` is computed at 11 bits, then clamped to [-511, +511].
- Pot format:
  - `pot_x = {1'b0, pos_x, lfsr[0]}`.
  - `pot_y = {1'b0, pos_y, lfsr[1]}`.
- Buttons:
  - `joy_btn[4]` (fire) = left.
  - `joy_btn[0]` (up) = right.
  - Bits 3:1 are always 0.
- `enable`=0:
  - `pend_x`/`pend_y` are cleared every cycle; strobes and ticks are ignored.
  - `pos` and `lfsr` are held.
  - `pot_x` = `pot_y` = 8'hFF (open paddle); `joy_btn` = 0.
- `enable` rising:
  - Pots show current `pos` from the next cycle.
  - Motion received before enable is discarded.

## Timing

- All outputs are registered.
- Reset values:
  - `pot_x` = `pot_y` = 8'hFF; `joy_btn` = 0.
  - `pend` = 0; `pos` = 0; `lfsr` = `LFSR_SEED`.
- Strobe in cycle N: `pend` updated at N+1; the position moves only on a later tick.
- Tick in cycle N: `pos`, `lfsr`, `pot_x`, `pot_y` updated at N+1. The pots are derived from the next-state `pos` and `lfsr`, so there is no extra cycle.
- Buttons: `mouse_btns` sampled on `mouse_strobe` and registered; `joy_btn` changes at N+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Reset has priority over `tick` and `mouse_strobe`.
- Back-to-back strobes on every cycle are accepted; there is no handshake or backpressure.

## Test plan

- Reset:
  - Apply reset with `enable`=1, then release.
  - Required: `pot_x` = `pot_y` = 8'hFF until the first post-reset cycle, then `pot_x[6:1]` = 0 and `joy_btn` = 0.
- Single step:
  - Apply strobe x=+5, y=+3, then one tick.
  - Required: `pos_x` = 5; `pos_y` = 61 (-3 mod 64); `pot_x[6:1]` = 6'd5; `pend` = 0.
- Rate limiting:
  - Apply strobe x=+100, then 5 ticks.
  - Required: `pos_x` sequence 31, 62, 29, 36, 36 (steps 31, 31, 31, 7, 0).
- Simultaneous events:
  - Set `pend_x` = 40, then in one cycle apply tick plus strobe x=-8.
  - Required: `pos_x` += 31; `pend_x` = 1.
- Saturation and wrap:
  - Apply six strobes x=+127.
  - Required: `pend_x` = 511 (not 762).
  - From `pos_x` = 63, a step of +1 gives 0; from 0, a step of -1 gives 63.
- Disable:
  - Deassert `enable` with `pend_x` ≠ 0, left button held.
  - Required: pots = 8'hFF; `joy_btn` = 0; `pend` cleared; `pos` unchanged on re-enable.
